// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = x - y, LSB first, one bit per clock.
// Ports: clk, rst (async, active-high), start, x, y -> busy, done, d, bo, ov.
//   start  request, sampled only while busy = 0
//   x, y   minuend / subtrahend, captured on the accepting edge
//   busy   high while an operation is running
//   done   one-cycle pulse when d / bo / ov update
//   d      (x - y) mod 2^W, held until the next done
//   bo     unsigned borrow-out (x < y)
//   ov     two's-complement overflow of x - y
module serial_subtractor #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic         bo,
    output logic         ov
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;

    logic [W-1:0]   xs_q, xs_d;
    logic [W-1:0]   ys_q, ys_d;
    logic [W-1:0]   ps_q, ps_d;
    logic           b_q, b_d;
    logic [CW-1:0]  i_q, i_d;

    // Operand sign bits, kept because xs/ys are shifted away.
    logic           xm_q, xm_d;
    logic           ym_q, ym_d;

    logic [W-1:0]   d_q, d_d;
    logic           bo_q, bo_d;
    logic           ov_q, ov_d;
    logic           done_q, done_d;

    logic           bit_a;
    logic           bit_c;
    logic           diff_bit;
    logic           borrow_nxt;
    logic           last_bit;
    logic [W-1:0]   res;

    assign bit_a      = xs_q[0];
    assign bit_c      = ys_q[0];
    assign diff_bit   = bit_a ^ bit_c ^ b_q;
    assign borrow_nxt = (~bit_a & bit_c) | (~(bit_a ^ bit_c) & b_q);
    assign last_bit   = (i_q == CW'(W - 1));

    // New difference bit enters from the MSB side; after W shifts
    // the first bit computed has reached bit 0.
    assign res = {diff_bit, ps_q[W-1:1]};

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        ps_d    = ps_q;
        b_d     = b_q;
        i_d     = i_q;
        xm_d    = xm_q;
        ym_d    = ym_q;
        d_d     = d_q;
        bo_d    = bo_q;
        ov_d    = ov_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    xs_d    = x;
                    ys_d    = y;
                    ps_d    = '0;
                    b_d     = 1'b0;
                    i_d     = '0;
                    xm_d    = x[W-1];
                    ym_d    = y[W-1];
                end
            end
            RUN: begin
                xs_d = xs_q >> 1;
                ys_d = ys_q >> 1;
                ps_d = res;
                b_d  = borrow_nxt;
                i_d  = i_q + CW'(1);
                if (last_bit) begin
                    state_d = IDLE;
                    i_d     = '0;
                    d_d     = res;
                    bo_d    = borrow_nxt;
                    // Overflow only when operand signs differ and the
                    // result sign disagrees with the minuend sign.
                    ov_d    = (xm_q ^ ym_q) & (res[W-1] ^ xm_q);
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            ps_q    <= '0;
            b_q     <= 1'b0;
            i_q     <= '0;
            xm_q    <= 1'b0;
            ym_q    <= 1'b0;
            d_q     <= '0;
            bo_q    <= 1'b0;
            ov_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            ps_q    <= ps_d;
            b_q     <= b_d;
            i_q     <= i_d;
            xm_q    <= xm_d;
            ym_q    <= ym_d;
            d_q     <= d_d;
            bo_q    <= bo_d;
            ov_q    <= ov_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign d    = d_q;
    assign bo   = bo_q;
    assign ov   = ov_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (W = 6).
// Explicit compare at each check point; summary line at the end.
module tb_serial_subtractor;

  localparam int W = 6;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bo;
  logic         ov;

  int checks = 0;
  int errors = 0;
  int n_done = 0;

  logic [W+1:0] prev_res;

  serial_subtractor #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo),
    .ov    (ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) n_done++;
  end

  task automatic fail(input string tag);
    errors++;
    $error("FAIL %s at %0t", tag, $time);
  endtask

  function automatic logic [W+1:0] model(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    int sa;
    int sb;
    int r;
    logic [W-1:0] dd;
    logic eb;
    logic eo;
    sa = a[W-1] ? int'(a) - 64 : int'(a);
    sb = b[W-1] ? int'(b) - 64 : int'(b);
    r  = sa - sb;
    dd = W'((int'(a) - int'(b) + 64) % 64);
    eb = (a < b);
    eo = (r < -32) || (r > 31);
    return {dd, eb, eo};
  endfunction

  task automatic run_op(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [W+1:0] exp_res,
    input bit hold
  );
    start = 1'b1;
    x     = a;
    y     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    x     = ~a;
    y     = ~b;
    checks++;
    if (busy !== 1'b1) fail("busy_at_accept");
    checks++;
    if (done !== 1'b0) fail("done_at_accept");
    for (int k = 1; k <= W; k++) begin
      if (hold) begin
        checks++;
        if ({d, bo, ov} !== prev_res)
          fail("hold_outputs");
      end
      @(posedge clk);
      #1;
      if (k < W) begin
        checks++;
        if ({busy, done} !== 2'b10)
          fail("busy_in_run");
      end
    end
    checks++;
    if ({busy, done} !== 2'b01) fail("done_at_E+W");
    checks++;
    if ({d, bo, ov} !== exp_res) fail("result");
    prev_res = {d, bo, ov};
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) fail("done_one_cycle");
    checks++;
    if ({d, bo, ov} !== exp_res) fail("result_held");
  endtask

  initial begin
    int lat;
    int base_done;
    rst   = 1'b1;
    start = 1'b0;
    x     = '0;
    y     = '0;
    prev_res = '0;
    #12;
    checks++;
    if ({busy, done, d, bo, ov} !== 10'b0)
      fail("reset_state");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) fail("idle_after_reset");

    run_op(6'd5, 6'd3, {6'd2, 1'b0, 1'b0}, 1'b1);
    run_op(6'd3, 6'd5, {6'd62, 1'b1, 1'b0}, 1'b1);
    run_op(6'd32, 6'd1, {6'd31, 1'b0, 1'b1}, 1'b1);
    run_op(6'd31, 6'd63, {6'd32, 1'b1, 1'b1}, 1'b1);

    base_done = n_done;
    start = 1'b1;
    x     = 6'd10;
    y     = 6'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    start = 1'b1;
    x     = 6'd1;
    y     = 6'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10) fail("mid_start_busy");
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (done !== 1'b0) fail("mid_start_not_done");
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b01) fail("mid_start_done");
    checks++;
    if ({d, bo, ov} !== {6'd6, 1'b0, 1'b0})
      fail("mid_start_result");
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (n_done - base_done !== 1)
      fail("mid_start_one_done");
    checks++;
    if (busy !== 1'b0) fail("mid_start_idle");

    start = 1'b1;
    x     = 6'd20;
    y     = 6'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (busy !== 1'b1) fail("pre_abort_busy");
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, d, bo, ov} !== 10'b0)
      fail("abort_clears");
    @(negedge clk);
    rst = 1'b0;
    base_done = n_done;
    for (int k = 0; k < W + 2; k++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (n_done - base_done !== 0) fail("abort_no_done");
    prev_res = '0;
    run_op(6'd63, 6'd63, {6'd0, 1'b0, 1'b0}, 1'b1);

    base_done = n_done;
    start = 1'b1;
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        x = W'(a);
        y = W'(b);
        @(posedge clk);
        #1;
        lat = 0;
        do begin
          @(posedge clk);
          #1;
          lat++;
        end while (!done && lat < W + 2);
        checks++;
        if (lat !== W) fail("sweep_latency");
        checks++;
        if ({d, bo, ov} !== model(W'(a), W'(b)))
          fail("sweep_result");
      end
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (n_done - base_done !== 4096)
      fail("sweep_done_count");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $fatal(1, "timeout");
  end

endmodule
